lu_cmd_issuer: RTL and testbench

- Initiator and response side for the 4-bit logic unit (LU).
- Accepts operation requests (A, B, op, tag) over a valid/ready interface and buffers them in a small FIFO.
- Drives one request at a time onto the LU's combinational inputs, samples its result X, and returns a tagged response over a second valid/ready interface.
- Checks every sampled result against a built-in golden model and counts mismatches. The block is the LU's test/host wrapper.

---
 rtl/lu_cmd_issuer_if.sv | 33 +++
 rtl/lu_cmd_issuer.sv | 186 ++++++++++++++++++
 tb/tb_lu_cmd_issuer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lu_cmd_issuer_if.sv
// Request/response handshake bundle between a host and the LU command issuer.
// The host side is the master; the issuer is the slave.
interface lu_cmd_issuer_if #(
  parameter int WIDTH = 4,
  parameter int TAG_W = 2
) ();
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [1:0]       req_op;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_x;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_x, rsp_tag, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag,
    output req_ready,
    output rsp_valid, rsp_x, rsp_tag, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/lu_cmd_issuer.sv
// Host wrapper for the 4-bit logic unit: queues requests, drives the LU one at a time,
// returns tagged results and flags any result that disagrees with the golden opcode map.
module lu_cmd_issuer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  lu_cmd_issuer_if.slave   bus,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [1:0]       lu_c,
  input  logic [WIDTH-1:0] lu_x,
  output logic [7:0]       err_count,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] mem_a   [DEPTH];
  logic [WIDTH-1:0] mem_b   [DEPTH];
  logic [1:0]       mem_op  [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [WIDTH-1:0] lu_a_reg, lu_b_reg;
  logic [1:0]       lu_c_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [WIDTH-1:0] exp_reg;

  logic             rsp_valid_reg;
  logic [WIDTH-1:0] rsp_x_reg;
  logic [TAG_W-1:0] rsp_tag_reg;
  logic             rsp_err_reg;
  logic [7:0]       err_count_reg;

  logic full, empty, push, pop, capture, rsp_done, mismatch;

  function automatic logic [WIDTH-1:0] golden(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = '1;
      2'b01:   r = a | b;
      2'b10:   r = '0;
      default: r = a & b;
    endcase
    return r;
  endfunction

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign push  = bus.req_valid && !full;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  assign mismatch = (lu_x != exp_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Storage carries no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_reg]   <= bus.req_a;
      mem_b[wr_ptr_reg]   <= bus.req_b;
      mem_op[wr_ptr_reg]  <= bus.req_op;
      mem_tag[wr_ptr_reg] <= bus.req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_a_reg <= '0;
      lu_b_reg <= '0;
      lu_c_reg <= 2'b00;
      tag_reg  <= '0;
      exp_reg  <= '0;
    end else if (pop) begin
      lu_a_reg <= mem_a[rd_ptr_reg];
      lu_b_reg <= mem_b[rd_ptr_reg];
      lu_c_reg <= mem_op[rd_ptr_reg];
      tag_reg  <= mem_tag[rd_ptr_reg];
      exp_reg  <= golden(mem_op[rd_ptr_reg], mem_a[rd_ptr_reg], mem_b[rd_ptr_reg]);
    end
  end

  // Response fields only change on capture, so they stay frozen while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_x_reg     <= '0;
      rsp_tag_reg   <= '0;
      rsp_err_reg   <= 1'b0;
      err_count_reg <= '0;
    end else begin
      if (capture) begin
        rsp_valid_reg <= 1'b1;
        rsp_x_reg     <= lu_x;
        rsp_tag_reg   <= tag_reg;
        rsp_err_reg   <= mismatch;
        if (mismatch && (err_count_reg != 8'hFF)) begin
          err_count_reg <= err_count_reg + 8'd1;
        end
      end else if (rsp_done) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.req_ready = !full;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_x     = rsp_x_reg;
  assign bus.rsp_tag   = rsp_tag_reg;
  assign bus.rsp_err   = rsp_err_reg;

  assign lu_a      = lu_a_reg;
  assign lu_b      = lu_b_reg;
  assign lu_c      = lu_c_reg;
  assign err_count = err_count_reg;
  assign busy      = (state_reg != IDLE) || !empty;

endmodule

// File: tb/tb_lu_cmd_issuer.sv
// Directed self-checking bench for lu_cmd_issuer with a behavioural LU that can be
// made to return a wrong result for opcode 00.
module tb_lu_cmd_issuer;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] lu_a, lu_b, lu_x;
  logic [1:0]       lu_c;
  logic [7:0]       err_count;
  logic             busy;
  logic             fault_en;

  always #5 clk = ~clk;

  lu_cmd_issuer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  lu_cmd_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .lu_a      (lu_a),
    .lu_b      (lu_b),
    .lu_c      (lu_c),
    .lu_x      (lu_x),
    .err_count (err_count),
    .busy      (busy)
  );

  // Stand-in logic unit
  always_comb begin
    case (lu_c)
      2'b00:   lu_x = 4'b1111;
      2'b01:   lu_x = lu_a | lu_b;
      2'b10:   lu_x = 4'b0000;
      default: lu_x = lu_a & lu_b;
    endcase
    if (fault_en && (lu_c == 2'b00)) lu_x = 4'b0000;
  end

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  rsp_t rsp_q[$];

  always @(posedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      rsp_q.push_back({bus.rsp_x, bus.rsp_tag, bus.rsp_err});
      $display("[TB] rsp x=%b tag=%0d err=%0b", bus.rsp_x, bus.rsp_tag, bus.rsp_err);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] op, input logic [1:0] tag);
    logic ok;
    logic accepted;
    accepted      = 1'b0;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.req_tag   = tag;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ok = bus.req_ready;
      step();
      if (ok) begin
        accepted = 1'b1;
        break;
      end
    end
    bus.req_valid = 1'b0;
    check("push_accept", 32'(accepted), 32'd1);
  endtask

  task automatic wait_rsps(input int n);
    for (int i = 0; i < 2000 && rsp_q.size() < n; i++) step();
    check("rsp_count", 32'(rsp_q.size()), 32'(n));
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !bus.rsp_valid; i++) step();
    check("rsp_valid_wait", 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic check_rsp(input string name, input logic [3:0] x,
                           input logic [1:0] tag, input logic err);
    rsp_t r;
    r = 'x;
    if (rsp_q.size() > 0) r = rsp_q.pop_front();
    check({name, "_x"},   32'(r.x),   32'(x));
    check({name, "_tag"}, 32'(r.tag), 32'(tag));
    check({name, "_err"}, 32'(r.err), 32'(err));
  endtask

  initial begin
    int nerr;
    rst           = 1'b1;
    fault_en      = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_lu_a",      32'(lu_a),          32'd0);
    check("rst_lu_c",      32'(lu_c),          32'd0);
    check("rst_rsp_x",     32'(bus.rsp_x),     32'd0);
    check("rst_err_count", 32'(err_count),     32'd0);
    rst = 1'b0;
    step();

    // Single request latency: handshake at E0, pop at E1, rsp_valid from E2
    push(4'b1010, 4'b0110, 2'b01, 2'd1);
    check("t1_e0_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    check("t1_e1_valid", 32'(bus.rsp_valid), 32'd0);
    check("t1_e1_lu_a",  32'(lu_a),          32'(4'b1010));
    check("t1_e1_lu_b",  32'(lu_b),          32'(4'b0110));
    check("t1_e1_lu_c",  32'(lu_c),          32'(2'b01));
    check("t1_e1_busy",  32'(busy),          32'd1);
    step();
    check("t1_e2_valid", 32'(bus.rsp_valid), 32'd1);
    check("t1_e2_x",     32'(bus.rsp_x),     32'(4'b1110));
    check("t1_e2_tag",   32'(bus.rsp_tag),   32'd1);
    check("t1_e2_err",   32'(bus.rsp_err),   32'd0);
    bus.rsp_ready = 1'b1;
    step();
    check("t1_done_valid", 32'(bus.rsp_valid), 32'd0);
    check_rsp("t1", 4'b1110, 2'd1, 1'b0);

    // All four opcodes back to back
    push(4'b1100, 4'b1010, 2'b00, 2'd0);
    push(4'b1100, 4'b1010, 2'b01, 2'd1);
    push(4'b1100, 4'b1010, 2'b10, 2'd2);
    push(4'b1100, 4'b1010, 2'b11, 2'd3);
    wait_rsps(4);
    check_rsp("t2_op00", 4'b1111, 2'd0, 1'b0);
    check_rsp("t2_op01", 4'b1110, 2'd1, 1'b0);
    check_rsp("t2_op10", 4'b0000, 2'd2, 1'b0);
    check_rsp("t2_op11", 4'b1000, 2'd3, 1'b0);
    check("t2_err_count", 32'(err_count), 32'd0);

    // Backpressure: one in flight plus four queued fills the issuer
    bus.rsp_ready = 1'b0;
    push(4'b0011, 4'b0101, 2'b01, 2'd0);
    push(4'b1111, 4'b0000, 2'b11, 2'd1);
    push(4'b0110, 4'b1010, 2'b00, 2'd2);
    push(4'b1001, 4'b1001, 2'b10, 2'd3);
    push(4'b1110, 4'b0111, 2'b11, 2'd0);
    check("t3_full_ready", 32'(bus.req_ready), 32'd0);
    check("t3_valid",      32'(bus.rsp_valid), 32'd1);
    bus.req_a     = 4'b0101;
    bus.req_b     = 4'b1010;
    bus.req_op    = 2'b01;
    bus.req_tag   = 2'd1;
    bus.req_valid = 1'b1;
    step();
    step();
    step();
    check("t3_stall_ready", 32'(bus.req_ready),  32'd0);
    check("t3_stall_x",     32'(bus.rsp_x),      32'(4'b0111));
    check("t3_stall_tag",   32'(bus.rsp_tag),    32'd0);
    check("t3_stall_none",  32'(rsp_q.size()),   32'd0);
    bus.rsp_ready = 1'b1;
    push(4'b0101, 4'b1010, 2'b01, 2'd1);
    wait_rsps(6);
    check_rsp("t3_r0", 4'b0111, 2'd0, 1'b0);
    check_rsp("t3_r1", 4'b0000, 2'd1, 1'b0);
    check_rsp("t3_r2", 4'b1111, 2'd2, 1'b0);
    check_rsp("t3_r3", 4'b0000, 2'd3, 1'b0);
    check_rsp("t3_r4", 4'b0110, 2'd0, 1'b0);
    check_rsp("t3_r5", 4'b1111, 2'd1, 1'b0);

    // Fault injection and error-counter saturation
    fault_en = 1'b1;
    push(4'b0000, 4'b0000, 2'b00, 2'd1);
    wait_rsps(1);
    check_rsp("t4_first", 4'b0000, 2'd1, 1'b1);
    check("t4_count1", 32'(err_count), 32'd1);
    for (int i = 0; i < 300; i++) push(4'(i), 4'(i >> 4), 2'b00, 2'(i));
    wait_rsps(300);
    nerr = 0;
    for (int i = 0; i < 300 && rsp_q.size() > 0; i++) begin
      rsp_t r;
      r = rsp_q.pop_front();
      nerr += int'(r.err);
    end
    check("t4_err_flags", 32'(nerr),      32'd300);
    check("t4_saturated", 32'(err_count), 32'd255);
    fault_en = 1'b0;
    push(4'b1100, 4'b1010, 2'b11, 2'd2);
    wait_rsps(1);
    check_rsp("t4_clean", 4'b1000, 2'd2, 1'b0);
    check("t4_still_sat", 32'(err_count), 32'd255);

    // Reset while a response is pending with three requests queued
    bus.rsp_ready = 1'b0;
    push(4'd1, 4'd2, 2'b01, 2'd0);
    push(4'd3, 4'd4, 2'b11, 2'd1);
    push(4'd5, 4'd6, 2'b01, 2'd2);
    push(4'd7, 4'd8, 2'b11, 2'd3);
    wait_valid();
    check("t5_pre_lu_c", 32'(lu_c), 32'(2'b01));
    rst = 1'b1;
    step();
    check("t5_valid",     32'(bus.rsp_valid), 32'd0);
    check("t5_req_ready", 32'(bus.req_ready), 32'd1);
    check("t5_busy",      32'(busy),          32'd0);
    check("t5_lu_c",      32'(lu_c),          32'd0);
    check("t5_lu_a",      32'(lu_a),          32'd0);
    check("t5_err_count", 32'(err_count),     32'd0);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("t5_no_stale", 32'(rsp_q.size()), 32'd0);
    check("t5_idle",     32'(busy),         32'd0);

    // Push coinciding with pop while two entries are queued
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(4'(i), 4'd0, 2'b01, 2'(i));
    wait_valid();
    bus.rsp_ready = 1'b1;
    for (int i = 3; i < 13; i++) begin
      wait_valid();
      step();
      bus.req_a     = 4'(i);
      bus.req_b     = 4'd0;
      bus.req_op    = 2'b01;
      bus.req_tag   = 2'(i);
      bus.req_valid = 1'b1;
      check("t6_ready", 32'(bus.req_ready), 32'd1);
      step();
      bus.req_valid = 1'b0;
    end
    wait_rsps(13);
    for (int i = 0; i < 13; i++) check_rsp("t6_order", 4'(i), 2'(i), 1'b0);
    check("t6_drained", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
